// File: rtl/async_fifo_rd_streamer.sv
// Read-side streamer for async_fifo: pops words in the rclk domain and re-presents them
// on a valid/ready stream through a 3-entry in-order buffer, with optional burst gating.
module async_fifo_rd_streamer #(
  parameter int    DSIZE       = 16,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    BURST_MODE  = 0,
  parameter int    TIMEOUT     = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  input  logic             arempty,
  input  logic             flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [DSIZE-1:0] o_data,
  output logic [31:0]      o_count
);

  localparam bit          FT_MODE    = (FALLTHROUGH == "TRUE");
  localparam bit          BURST_EN   = (BURST_MODE != 0);
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [31:0]      timer_r, timer_s;
  logic [1:0]       occ_r, occ_s;
  logic [1:0]       wr_idx_s;
  logic             inflight_r;
  logic             valid_r;
  logic [31:0]      count_r;
  logic [DSIZE-1:0] buf_r   [3];
  logic [DSIZE-1:0] buf_s   [3];
  logic [DSIZE-1:0] shift_s [3];
  logic             rinc_s;
  logic             pop_s;
  logic             capture_s;

  // Pop strobe depends only on registered state and FIFO flags, never on o_ready.
  always_comb begin
    rinc_s    = (state_r == ST_DRAIN) && !rempty &&
                (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd3);
    pop_s     = valid_r && o_ready;
    capture_s = FT_MODE ? rinc_s : inflight_r;
  end

  // Next-state logic for the read-gating FSM and its fill timer.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    case (state_r)
      ST_IDLE: begin
        if (rempty) begin
          state_s = ST_IDLE;
        end else if (!BURST_EN) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FILL;
          timer_s = 32'd0;
        end
      end
      ST_FILL: begin
        timer_s = timer_r + 32'd1;
        if (!arempty || flush || (timer_r == TIMEOUT_M1)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DRAIN: begin
        // A registered-read word still in flight is captured after leaving DRAIN.
        if (rempty && !rinc_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = 32'd0;
      end
    endcase
  end

  // Buffer update: consume shifts toward the head, capture lands behind the survivors.
  always_comb begin
    occ_s      = occ_r + {1'b0, capture_s} - {1'b0, pop_s};
    wr_idx_s   = occ_r - {1'b0, pop_s};
    shift_s[0] = pop_s ? buf_r[1] : buf_r[0];
    shift_s[1] = pop_s ? buf_r[2] : buf_r[1];
    shift_s[2] = buf_r[2];
    for (int i = 0; i < 3; i++) begin
      if (capture_s && (wr_idx_s == 2'(i))) begin
        buf_s[i] = rdata;
      end else begin
        buf_s[i] = shift_s[i];
      end
    end
  end

  // State, buffer and counter registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r    <= ST_IDLE;
      timer_r    <= 32'd0;
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      count_r    <= 32'd0;
      for (int i = 0; i < 3; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      occ_r      <= occ_s;
      inflight_r <= FT_MODE ? 1'b0 : rinc_s;
      valid_r    <= (occ_s != 2'd0);
      count_r    <= count_r + {31'd0, pop_s};
      for (int i = 0; i < 3; i++) begin
        buf_r[i] <= buf_s[i];
      end
    end
  end

  assign rinc    = rinc_s;
  assign o_valid = valid_r;
  assign o_data  = buf_r[0];
  assign o_count = count_r;

endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// Directed bench: three streamer instances (fallthrough, registered-read, burst) each fed
// by a behavioural FIFO; delivered words are scoreboarded against the pushed data.
module tb_async_fifo_rd_streamer;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFOs: bench pushes at wp, DUT pops at rp
  logic [15:0] mem0 [8192];
  logic [15:0] mem1 [8192];
  logic [15:0] mem2 [8192];
  logic [12:0] wp0 = '0, wp1 = '0, wp2 = '0;
  logic [12:0] rp0 = '0, rp1 = '0, rp2 = '0;
  logic [12:0] acc0 = '0, acc1 = '0, acc2 = '0;

  logic        rinc0, rinc1, rinc2;
  logic [15:0] rdata0, rdata2;
  logic [15:0] rdata1 = '0;
  logic        rempty0, rempty1, rempty2, arempty0, arempty1, arempty2;
  logic        o_valid0, o_valid1, o_valid2;
  logic        o_ready0 = 1'b0, o_ready1 = 1'b0, o_ready2 = 1'b0;
  logic        flush2 = 1'b0;
  logic [15:0] o_data0, o_data1, o_data2;
  logic [31:0] o_count0, o_count1, o_count2;

  assign rempty0  = (wp0 == rp0);
  assign rempty1  = (wp1 == rp1);
  assign rempty2  = (wp2 == rp2);
  assign arempty0 = ((wp0 - rp0) <= 13'd1);
  assign arempty1 = ((wp1 - rp1) <= 13'd1);
  assign arempty2 = ((wp2 - rp2) <= 13'd1);
  assign rdata0   = mem0[rp0];
  assign rdata2   = mem2[rp2];

  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rp0 <= wp0;
      rp1 <= wp1;
      rp2 <= wp2;
    end else begin
      if (rinc0) rp0 <= rp0 + 13'd1;
      if (rinc1) begin
        rp1    <= rp1 + 13'd1;
        rdata1 <= mem1[rp1];
      end
      if (rinc2) rp2 <= rp2 + 13'd1;
    end
  end

  async_fifo_rd_streamer #(.DSIZE(16), .FALLTHROUGH("TRUE"), .BURST_MODE(0), .TIMEOUT(16)) u_ft (
    .rclk(rclk), .rrst(rrst), .rinc(rinc0), .rdata(rdata0), .rempty(rempty0), .arempty(arempty0),
    .flush(1'b0), .o_valid(o_valid0), .o_ready(o_ready0), .o_data(o_data0), .o_count(o_count0));

  async_fifo_rd_streamer #(.DSIZE(16), .FALLTHROUGH("FALSE"), .BURST_MODE(0), .TIMEOUT(16)) u_reg (
    .rclk(rclk), .rrst(rrst), .rinc(rinc1), .rdata(rdata1), .rempty(rempty1), .arempty(arempty1),
    .flush(1'b0), .o_valid(o_valid1), .o_ready(o_ready1), .o_data(o_data1), .o_count(o_count1));

  async_fifo_rd_streamer #(.DSIZE(16), .FALLTHROUGH("TRUE"), .BURST_MODE(1), .TIMEOUT(16)) u_bst (
    .rclk(rclk), .rrst(rrst), .rinc(rinc2), .rdata(rdata2), .rempty(rempty2), .arempty(arempty2),
    .flush(flush2), .o_valid(o_valid2), .o_ready(o_ready2), .o_data(o_data2), .o_count(o_count2));

  task automatic push0(input logic [15:0] v);
    mem0[wp0] = v;
    wp0 = wp0 + 13'd1;
  endtask
  task automatic push1(input logic [15:0] v);
    mem1[wp1] = v;
    wp1 = wp1 + 13'd1;
  endtask
  task automatic push2(input logic [15:0] v);
    mem2[wp2] = v;
    wp2 = wp2 + 13'd1;
  endtask

  // Scoreboard: every accepted word must be the next pushed word; hold and occupancy rules.
  logic        hold1 = 1'b0;
  logic [15:0] hold_d1 = '0;
  always begin
    @(negedge rclk);
    #2;
    if (rrst) begin
      acc0  <= wp0;
      acc1  <= wp1;
      acc2  <= wp2;
      hold1 <= 1'b0;
    end else begin
      if (o_valid0 && o_ready0) begin
        chk("ft_data", 32'(o_data0), 32'(mem0[acc0]));
        acc0 <= acc0 + 13'd1;
      end
      if (o_valid1 && o_ready1) begin
        chk("reg_data", 32'(o_data1), 32'(mem1[acc1]));
        acc1 <= acc1 + 13'd1;
      end
      if (o_valid2 && o_ready2) begin
        chk("bst_data", 32'(o_data2), 32'(mem2[acc2]));
        acc2 <= acc2 + 13'd1;
      end
      if (hold1) begin
        chk("reg_hold_valid", 32'(o_valid1), 32'd1);
        chk("reg_hold_data", 32'(o_data1), 32'(hold_d1));
      end
      chk("reg_occ_le3", 32'((rp1 - acc1) <= 13'd3), 32'd1);
      hold1   <= o_valid1 && !o_ready1;
      hold_d1 <= o_data1;
    end
  end

  logic [31:0] wrap_exp [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

  initial begin
    int          first;
    int          j;
    int          k;
    logic [31:0] last;

    // Reset state and reset in the middle of a drain
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("rst_valid", 32'(o_valid0), 32'd0);
    chk("rst_count", o_count0, 32'd0);
    rrst = 1'b0;
    @(negedge rclk);
    push0(16'h1111); push0(16'h2222); push0(16'h3333); push0(16'h4444);
    repeat (4) @(negedge rclk);
    chk("t1_full_valid", 32'(o_valid0), 32'd1);
    chk("t1_head", 32'(o_data0), 32'h1111);
    o_ready0 = 1'b1;
    @(negedge rclk);
    o_ready0 = 1'b0;
    #1;
    chk("t1_head2", 32'(o_data0), 32'h2222);
    chk("t1_rinc_pre", 32'(rinc0), 32'd1);
    chk("t1_count_pre", o_count0, 32'd1);
    rrst = 1'b1;
    #1;
    chk("t1_rst_valid", 32'(o_valid0), 32'd0);
    chk("t1_rst_rinc", 32'(rinc0), 32'd0);
    chk("t1_rst_count", o_count0, 32'd0);
    chk("t1_rst_data", 32'(o_data0), 32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    #1;
    chk("t1_post_valid", 32'(o_valid0), 32'd0);

    // Fallthrough streaming of 0..4095 at full rate
    @(negedge rclk);
    push0(16'd0);
    #1;
    chk("t2_idle_norinc", 32'(rinc0), 32'd0);
    for (int i = 1; i < 4096; i++) push0(16'(i));
    o_ready0 = 1'b1;
    first = -1;
    j = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge rclk);
      #1;
      if (first < 0 && o_valid0) first = c;
      j = c;
      if (o_count0 == 32'd4096) break;
    end
    chk("t2_count", o_count0, 32'd4096);
    chk("t2_rate", 32'(j - first), 32'd4096);
    chk("t2_rinc_empty", 32'(rinc0), 32'd0);
    chk("t2_valid_empty", 32'(o_valid0), 32'd0);

    // Registered-read FIFO with o_ready toggling
    @(negedge rclk);
    for (int i = 0; i < 256; i++) push1(16'hA000 + 16'(i));
    for (int c = 0; c < 3000; c++) begin
      o_ready1 = ~o_ready1;
      @(negedge rclk);
      #1;
      if (o_count1 == 32'd256) break;
    end
    chk("t3_count", o_count1, 32'd256);
    o_ready1 = 1'b1;
    repeat (3) @(negedge rclk);
    chk("t3_drained", 32'(o_valid1), 32'd0);

    // Registered-read FIFO at full rate
    for (int i = 0; i < 16; i++) push1(16'hB000 + 16'(i));
    first = -1;
    j = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge rclk);
      #1;
      if (first < 0 && o_valid1) first = c;
      j = c;
      if (o_count1 == 32'd272) break;
    end
    chk("t3_rate", 32'(j - first), 32'd16);

    // Burst mode: a lone word waits for the timeout
    o_ready2 = 1'b1;
    @(negedge rclk);
    push2(16'hC001);
    #1;
    chk("t4_rinc_idle", 32'(rinc2), 32'd0);
    j = 99;
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      #1;
      if (rinc2) begin
        j = c;
        break;
      end
    end
    chk("t4_timeout", 32'(j), 32'd16);
    repeat (4) @(negedge rclk);
    chk("t4_count1", o_count2, 32'd1);

    // Burst mode: drain as soon as arempty drops
    push2(16'hC002);
    @(negedge rclk);
    @(negedge rclk);
    push2(16'hC003); push2(16'hC004);
    #1;
    chk("t4_fill_hold", 32'(rinc2), 32'd0);
    @(negedge rclk);
    #1;
    chk("t4_arempty_drain", 32'(rinc2), 32'd1);
    repeat (5) @(negedge rclk);
    chk("t4_count4", o_count2, 32'd4);

    // Burst mode: flush forces an early drain
    push2(16'hC005);
    @(negedge rclk);
    flush2 = 1'b1;
    @(negedge rclk);
    flush2 = 1'b0;
    #1;
    chk("t5_flush_drain", 32'(rinc2), 32'd1);
    repeat (4) @(negedge rclk);
    chk("t5_count5", o_count2, 32'd5);
    chk("t5_idle_valid", 32'(o_valid2), 32'd0);
    chk("t5_idle_rinc", 32'(rinc2), 32'd0);

    // o_count wrap from a preloaded value
    force u_bst.count_r = 32'hFFFF_FFFE;
    @(negedge rclk);
    release u_bst.count_r;
    #1;
    chk("t6_preload", o_count2, 32'hFFFF_FFFE);
    push2(16'hC006); push2(16'hC007); push2(16'hC008);
    last = o_count2;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge rclk);
      #1;
      if (o_count2 != last) begin
        chk("t6_wrap", o_count2, wrap_exp[k]);
        last = o_count2;
        k++;
      end
      if (k == 3) break;
    end
    chk("t6_accepts", 32'(k), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
